// File: rtl/web_fire_controller.sv
// Web fire controller: validates a web request against fluid, energy and
// tracer resources, sequences shots and cooldowns, and handles reloads.
module web_fire_controller #(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned FLUID_W    = 4,
  parameter int unsigned TRACER_W   = 6,
  parameter int unsigned ENERGY_W   = 8,
  parameter int unsigned TASER_IDX  = 4,
  parameter int unsigned RAPID_IDX  = 5,
  parameter int unsigned TRACER_IDX = 6,
  parameter int unsigned TASER_E    = 64,
  parameter int unsigned RAPID_N    = 3,
  parameter int unsigned COOLDOWN   = 4,
  parameter int unsigned RELOAD_CYC = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SEL_W-1:0]      select,
  input  logic                  req,
  input  logic [ENERGY_W-1:0]   energy,
  output logic [2**SEL_W-1:0]   fire_onehot,
  output logic                  busy,
  output logic                  done,
  output logic                  denied,
  output logic [FLUID_W-1:0]    fluid_level,
  output logic [TRACER_W-1:0]   tracers_left
);

  localparam int unsigned N          = 2**SEL_W;
  localparam int unsigned FLUID_MAX  = 2**FLUID_W - 1;
  localparam int unsigned TRACER_MAX = 2**TRACER_W - 1;
  localparam int unsigned CD_W       = $clog2(COOLDOWN + 1);
  localparam int unsigned RL_W       = $clog2(RELOAD_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FIRE,
    ST_COOL,
    ST_RELOAD
  } state_t;

  state_t              state_q;
  logic [SEL_W-1:0]    idx_q;
  logic [SEL_W-1:0]    index_d;
  logic [FLUID_W-1:0]  fluid_q;
  logic [TRACER_W-1:0] tracers_q;
  logic [FLUID_W-1:0]  shots_q;
  logic [CD_W-1:0]     cd_cnt_q;
  logic [RL_W-1:0]     rl_cnt_q;
  logic [N-1:0]        fire_q;
  logic                busy_q;
  logic                done_q;
  logic                denied_q;
  logic                check_ok;

  // Web index is the bit-reversed select (select[0] is the index MSB).
  always_comb begin
    index_d = {<<{select}};
  end

  // Resource check for the latched web: fluid cost, taser energy, tracer stock.
  always_comb begin
    check_ok = 1'b1;
    if (idx_q == SEL_W'(RAPID_IDX)) begin
      if (fluid_q < FLUID_W'(RAPID_N)) check_ok = 1'b0;
    end else if (fluid_q == '0) begin
      check_ok = 1'b0;
    end
    if ((idx_q == SEL_W'(TASER_IDX)) && (energy < ENERGY_W'(TASER_E))) check_ok = 1'b0;
    if ((idx_q == SEL_W'(TRACER_IDX)) && (tracers_q == '0)) check_ok = 1'b0;
  end

  // Controller FSM with registered pulses and resource counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      fluid_q   <= FLUID_W'(FLUID_MAX);
      tracers_q <= TRACER_W'(TRACER_MAX);
      shots_q   <= '0;
      cd_cnt_q  <= '0;
      rl_cnt_q  <= '0;
      fire_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      denied_q  <= 1'b0;
    end else begin
      fire_q   <= '0;
      done_q   <= 1'b0;
      denied_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req && enable) begin
            idx_q   <= index_d;
            state_q <= ST_CHECK;
            busy_q  <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (idx_q == SEL_W'(N - 1)) begin
            state_q  <= ST_RELOAD;
            rl_cnt_q <= RL_W'(RELOAD_CYC - 1);
          end else if (check_ok) begin
            state_q       <= ST_FIRE;
            fire_q[idx_q] <= 1'b1;
            shots_q       <= (idx_q == SEL_W'(RAPID_IDX)) ? FLUID_W'(RAPID_N - 1) : '0;
          end else begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            denied_q <= 1'b1;
          end
        end
        ST_FIRE: begin
          // The shot has left the nozzle, so it is paid for even on abort.
          if (fluid_q != '0) fluid_q <= fluid_q - 1'b1;
          if ((idx_q == SEL_W'(TRACER_IDX)) && (tracers_q != '0)) tracers_q <= tracers_q - 1'b1;
          if (!enable) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q  <= ST_COOL;
            cd_cnt_q <= CD_W'(COOLDOWN - 1);
          end
        end
        ST_COOL: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cd_cnt_q == '0) begin
            if (shots_q != '0) begin
              state_q       <= ST_FIRE;
              fire_q[idx_q] <= 1'b1;
              shots_q       <= shots_q - 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cd_cnt_q <= cd_cnt_q - 1'b1;
          end
        end
        ST_RELOAD: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (rl_cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            fluid_q <= FLUID_W'(FLUID_MAX);
          end else begin
            rl_cnt_q <= rl_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fire_onehot  = fire_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign denied       = denied_q;
  assign fluid_level  = fluid_q;
  assign tracers_left = tracers_q;

endmodule

// File: tb/tb_web_fire_controller.sv
// Bench for web_fire_controller: vector table, directed multi-cycle
// sequences, and randomized traffic against a timeline reference model.
module tb_web_fire_controller;

  localparam int N          = 8;
  localparam int FLUID_MAX  = 15;
  localparam int TRACER_MAX = 63;
  localparam int TASER_IDX  = 4;
  localparam int RAPID_IDX  = 5;
  localparam int TRACER_IDX = 6;
  localparam int TASER_E    = 64;
  localparam int RAPID_N    = 3;
  localparam int COOLDOWN   = 4;
  localparam int RELOAD_CYC = 10;

  localparam int P_CHECK  = 0;
  localparam int P_FIRE   = 1;
  localparam int P_COOL   = 2;
  localparam int P_RELOAD = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] select;
  logic       req;
  logic [7:0] energy;
  logic [7:0] fire_onehot;
  logic       busy;
  logic       done;
  logic       denied;
  logic [3:0] fluid_level;
  logic [5:0] tracers_left;

  int checks   = 0;
  int failures = 0;

  web_fire_controller dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .select       (select),
    .req          (req),
    .energy       (energy),
    .fire_onehot  (fire_onehot),
    .busy         (busy),
    .done         (done),
    .denied       (denied),
    .fluid_level  (fluid_level),
    .tracers_left (tracers_left)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: a queue of upcoming phases, planned when a request is
  // accepted and when its check resolves; outputs follow from the plan.
  int         plan[$];
  int         m_fluid, m_tr, m_idx;
  logic [7:0] m_fire;
  logic       m_busy, m_done, m_denied;

  function automatic int rev(input logic [2:0] s);
    return int'(s[0]) * 4 + int'(s[1]) * 2 + int'(s[2]);
  endfunction

  always @(posedge clk) begin : ref_model
    int cur;
    int shots;
    bit ok;
    m_fire   = '0;
    m_done   = 1'b0;
    m_denied = 1'b0;
    if (reset) begin
      plan.delete();
      m_fluid = FLUID_MAX;
      m_tr    = TRACER_MAX;
    end else if (plan.size() == 0) begin
      if (req && enable) begin
        m_idx = rev(select);
        plan.push_back(P_CHECK);
      end
    end else begin
      cur = plan.pop_front();
      if (cur == P_FIRE) begin
        if (m_fluid > 0) m_fluid--;
        if (m_idx == TRACER_IDX && m_tr > 0) m_tr--;
      end
      if (!enable) begin
        plan.delete();
      end else if (cur == P_CHECK) begin
        ok = (m_fluid >= ((m_idx == RAPID_IDX) ? RAPID_N : 1));
        if (m_idx == TASER_IDX && int'(energy) < TASER_E) ok = 0;
        if (m_idx == TRACER_IDX && m_tr == 0) ok = 0;
        if (m_idx == N - 1) begin
          repeat (RELOAD_CYC) plan.push_back(P_RELOAD);
        end else if (ok) begin
          shots = (m_idx == RAPID_IDX) ? RAPID_N : 1;
          repeat (shots) begin
            plan.push_back(P_FIRE);
            repeat (COOLDOWN) plan.push_back(P_COOL);
          end
        end else begin
          m_denied = 1'b1;
        end
      end else if (plan.size() == 0) begin
        m_done = 1'b1;
        if (cur == P_RELOAD) m_fluid = FLUID_MAX;
      end
    end
    if (plan.size() > 0 && plan[0] == P_FIRE) m_fire = 8'(1 << m_idx);
    m_busy = (plan.size() > 0);
  end

  typedef struct {
    logic       req;
    logic       en;
    logic [2:0] sel;
    logic [7:0] energy;
    logic [7:0] fire;
    logic       busy;
    logic       done;
    logic       denied;
    logic [3:0] fluid;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic [2:0] s, input logic [7:0] en_v,
                              input logic [7:0] f, input logic b, input logic d, input logic dn,
                              input logic [3:0] fl);
    vec_t v;
    v.req = r; v.en = e; v.sel = s; v.energy = en_v;
    v.fire = f; v.busy = b; v.done = d; v.denied = dn; v.fluid = fl;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1; req = 1'b0; enable = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Issue one request and follow it to done or denied.
  task automatic do_req(input logic [2:0] sel, input logic [7:0] en_v, output bit got_done,
                        output bit got_denied, output logic [7:0] fire_or, output int cycles);
    select = sel; energy = en_v; req = 1'b1;
    tick();
    req = 1'b0;
    got_done = 0; got_denied = 0; fire_or = '0; cycles = 1;
    while (!got_done && !got_denied && cycles < 200) begin
      tick();
      cycles++;
      fire_or = fire_or | fire_onehot;
      if (done) got_done = 1;
      if (denied) got_denied = 1;
    end
    chk("req_completes", 32'(got_done | got_denied), 1);
  endtask

  vec_t tbl[19];

  initial begin
    bit         gd, gn;
    logic [7:0] fo;
    logic [7:0] acc_fire;
    logic       acc_done;
    int         cyc;
    int         since_reload;

    reset = 1'b1; enable = 1'b1; select = '0; req = 1'b0; energy = '0;

    //           req en  sel     energy  fire   busy done den  fluid
    tbl[0]  = mk(1, 1, 3'b100, 8'd0,  8'h00, 1, 0, 0, 4'd15);
    tbl[1]  = mk(0, 1, 3'b100, 8'd0,  8'h02, 1, 0, 0, 4'd15);
    tbl[2]  = mk(0, 1, 3'b100, 8'd0,  8'h00, 1, 0, 0, 4'd14);
    tbl[3]  = mk(0, 1, 3'b100, 8'd0,  8'h00, 1, 0, 0, 4'd14);
    tbl[4]  = mk(0, 1, 3'b100, 8'd0,  8'h00, 1, 0, 0, 4'd14);
    tbl[5]  = mk(0, 1, 3'b100, 8'd0,  8'h00, 1, 0, 0, 4'd14);
    tbl[6]  = mk(0, 1, 3'b100, 8'd0,  8'h00, 0, 1, 0, 4'd14);
    tbl[7]  = mk(0, 1, 3'b100, 8'd0,  8'h00, 0, 0, 0, 4'd14);
    tbl[8]  = mk(1, 1, 3'b001, 8'd63, 8'h00, 1, 0, 0, 4'd14);
    tbl[9]  = mk(0, 1, 3'b001, 8'd63, 8'h00, 0, 0, 1, 4'd14);
    tbl[10] = mk(1, 1, 3'b001, 8'd64, 8'h00, 1, 0, 0, 4'd14);
    tbl[11] = mk(0, 1, 3'b001, 8'd64, 8'h10, 1, 0, 0, 4'd14);
    tbl[12] = mk(1, 1, 3'b100, 8'd0,  8'h00, 1, 0, 0, 4'd13);
    tbl[13] = mk(0, 1, 3'b100, 8'd0,  8'h00, 1, 0, 0, 4'd13);
    tbl[14] = mk(0, 1, 3'b100, 8'd0,  8'h00, 1, 0, 0, 4'd13);
    tbl[15] = mk(0, 1, 3'b100, 8'd0,  8'h00, 1, 0, 0, 4'd13);
    tbl[16] = mk(0, 1, 3'b100, 8'd0,  8'h00, 0, 1, 0, 4'd13);
    tbl[17] = mk(1, 0, 3'b100, 8'd0,  8'h00, 0, 0, 0, 4'd13);
    tbl[18] = mk(0, 1, 3'b100, 8'd0,  8'h00, 0, 0, 0, 4'd13);

    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_fire", 32'(fire_onehot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_denied", 32'(denied), 0);
    chk("rst_fluid", 32'(fluid_level), 15);
    chk("rst_tracers", 32'(tracers_left), 63);

    // Vector table: single shot, taser energy threshold, busy/disabled requests
    for (int i = 0; i < 19; i++) begin
      req = tbl[i].req; enable = tbl[i].en; select = tbl[i].sel; energy = tbl[i].energy;
      tick();
      chk($sformatf("vec%0d_fire", i), 32'(fire_onehot), 32'(tbl[i].fire));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("vec%0d_denied", i), 32'(denied), 32'(tbl[i].denied));
      chk($sformatf("vec%0d_fluid", i), 32'(fluid_level), 32'(tbl[i].fluid));
    end
    req = 1'b0; enable = 1'b1;

    // Rapid burst from full fluid
    do_reset();
    select = 3'b101; req = 1'b1;
    tick();
    req = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      if (k > 1) tick();
      chk($sformatf("rapid_fire_t%0d", k), 32'(fire_onehot),
          (k == 2 || k == 7 || k == 12) ? 32'h20 : 32'h0);
      chk($sformatf("rapid_done_t%0d", k), 32'(done), (k == 17) ? 1 : 0);
    end
    chk("rapid_fluid", 32'(fluid_level), 12);

    // Drain to 2, rapid denied, then a full reload
    for (int i = 0; i < 10; i++) begin
      do_req(3'b000, 8'd0, gd, gn, fo, cyc);
      chk("drain_done", 32'(gd), 1);
    end
    chk("drain_fluid", 32'(fluid_level), 2);
    do_req(3'b101, 8'd0, gd, gn, fo, cyc);
    chk("rapid_low_denied", 32'(gn), 1);
    chk("rapid_low_nofire", 32'(fo), 0);
    chk("rapid_low_cycles", 32'(cyc), 2);
    chk("rapid_low_fluid", 32'(fluid_level), 2);
    select = 3'b111; req = 1'b1;
    tick();
    req = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) tick();
      chk($sformatf("reload_busy_t%0d", k), 32'(busy), (k <= 11) ? 1 : 0);
      chk($sformatf("reload_done_t%0d", k), 32'(done), (k == 12) ? 1 : 0);
      chk($sformatf("reload_fire_t%0d", k), 32'(fire_onehot), 0);
    end
    chk("reload_fluid", 32'(fluid_level), 15);

    // Tracer exhaustion with reloads interleaved
    since_reload = 0;
    for (int i = 0; i < 64; i++) begin
      if (since_reload == 15) begin
        do_req(3'b111, 8'd0, gd, gn, fo, cyc);
        chk("tracer_reload_done", 32'(gd), 1);
        since_reload = 0;
      end
      do_req(3'b011, 8'd0, gd, gn, fo, cyc);
      if (i < 63) begin
        chk($sformatf("tracer%0d_done", i), 32'(gd), 1);
        chk($sformatf("tracer%0d_fire", i), 32'(fo), 32'h40);
        since_reload++;
      end else begin
        chk("tracer64_denied", 32'(gn), 1);
        chk("tracer64_nofire", 32'(fo), 0);
      end
    end
    chk("tracers_empty", 32'(tracers_left), 0);
    chk("tracers_fluid", 32'(fluid_level), 12);

    // Abort rapid burst in cooldown, then reset in the middle of a reload
    do_reset();
    select = 3'b101; req = 1'b1;
    tick();
    req = 1'b0;
    tick(); tick(); tick();
    enable = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    enable = 1'b1;
    acc_fire = '0; acc_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      acc_fire = acc_fire | fire_onehot;
      acc_done = acc_done | done;
    end
    chk("abort_nofire", 32'(acc_fire), 0);
    chk("abort_nodone", 32'(acc_done), 0);
    chk("abort_fluid", 32'(fluid_level), 14);
    select = 3'b111; req = 1'b1;
    tick();
    req = 1'b0;
    tick(); tick(); tick();
    chk("mid_reload_busy", 32'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reload_rst_fluid", 32'(fluid_level), 15);
    chk("reload_rst_fire", 32'(fire_onehot), 0);
    chk("reload_rst_busy", 32'(busy), 0);
    chk("reload_rst_done", 32'(done), 0);
    chk("reload_rst_tracers", 32'(tracers_left), 63);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req    = ($urandom_range(0, 3) == 0);
      select = 3'($urandom);
      enable = ($urandom_range(0, 39) != 0);
      energy = 8'($urandom_range(40, 90));
      reset  = ($urandom_range(0, 499) == 0);
      tick();
      chk("rnd_fire", 32'(fire_onehot), 32'(m_fire));
      chk("rnd_busy", 32'(busy), 32'(m_busy));
      chk("rnd_done", 32'(done), 32'(m_done));
      chk("rnd_denied", 32'(denied), 32'(m_denied));
      chk("rnd_fluid", 32'(fluid_level), 32'(m_fluid));
      chk("rnd_tracers", 32'(tracers_left), 32'(m_tr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
